// File: rtl/seg_pkg.sv
// Shared glyph codes, segment bit positions and display-frame types for the
// 8-digit multiplexed seven-segment scanner.
package seg_pkg;
    localparam int NUM_DIGITS = 8;
    localparam int CODE_W     = 5;

    localparam logic [CODE_W-1:0] GLYPH_BLANK     = 5'h10;
    localparam logic [CODE_W-1:0] GLYPH_DASH      = 5'h11;
    localparam logic [CODE_W-1:0] GLYPH_UNDERSCORE = 5'h12;
    localparam logic [CODE_W-1:0] GLYPH_OVERLINE  = 5'h13;
    localparam logic [CODE_W-1:0] GLYPH_INVADER   = 5'h14;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    typedef struct packed {
        logic [NUM_DIGITS*CODE_W-1:0] code;
        logic [NUM_DIGITS-1:0]        dp;
    } disp_t;

    function automatic logic [CODE_W-1:0] digit_code(input disp_t d, input int k);
        return d.code[CODE_W*k +: CODE_W];
    endfunction

    // Phase p lights digit p on bank 0 and digit p+4 on bank 1.
    function automatic logic [NUM_DIGITS-1:0] en_of(input logic [1:0] p);
        logic [NUM_DIGITS-1:0] e;
        e = '0;
        e[{1'b0, p}] = 1'b1;
        e[{1'b1, p}] = 1'b1;
        return e;
    endfunction
endpackage

// File: rtl/seg_decode.sv
// Combinational glyph-code to seven-segment decode (bit0=a .. bit6=g, active-high).
module seg_decode
    import seg_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [6:0]        seg
);
    always_comb begin
        seg = '0;
        case (code)
            5'h00: seg = 7'h3F;
            5'h01: seg = 7'h06;
            5'h02: seg = 7'h5B;
            5'h03: seg = 7'h4F;
            5'h04: seg = 7'h66;
            5'h05: seg = 7'h6D;
            5'h06: seg = 7'h7D;
            5'h07: seg = 7'h07;
            5'h08: seg = 7'h7F;
            5'h09: seg = 7'h6F;
            5'h0A: seg = 7'h77;
            5'h0B: seg = 7'h7C;
            5'h0C: seg = 7'h39;
            5'h0D: seg = 7'h5E;
            5'h0E: seg = 7'h79;
            5'h0F: seg = 7'h71;
            GLYPH_DASH:       seg[SEG_G] = 1'b1;
            GLYPH_UNDERSCORE: seg[SEG_D] = 1'b1;
            GLYPH_OVERLINE:   seg[SEG_A] = 1'b1;
            GLYPH_INVADER: begin
                seg[SEG_A] = 1'b1;
                seg[SEG_B] = 1'b1;
                seg[SEG_F] = 1'b1;
                seg[SEG_G] = 1'b1;
            end
            default: seg = '0;
        endcase
    end
endmodule

// File: rtl/seg_scan.sv
// 8-digit seven-segment scanner: two digits per phase, blanking between phases,
// frame-atomic display updates applied only at the phase 3 -> 0 wrap.
module seg_scan
    import seg_pkg::*;
#(
    parameter int          BLANK_CYCLES = 2000,
    parameter logic [4:0]  BLANK_CODE   = 5'h10
) (
    input  logic        sys_clk_in,
    input  logic        sys_rst_n,
    input  logic        scan_clk,
    input  logic [39:0] disp_code,
    input  logic [7:0]  disp_dp,
    input  logic        disp_load,
    output logic [7:0]  an,
    output logic [7:0]  seg0,
    output logic [7:0]  seg1,
    output logic        frame_done,
    output logic        load_pending
);
    localparam int CW = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);
    localparam disp_t RST_DISP = '{code: {NUM_DIGITS{BLANK_CODE}}, dp: '0};

    logic          sync1, sync2, sync3;
    logic          scan_tick, wrap;
    logic [1:0]    phase, phase_nxt;
    logic [CW-1:0] blank_cnt;
    disp_t         shadow, pending, shad_nxt, disp_in;
    logic [6:0]    lo_seg, hi_seg;

    assign disp_in = '{code: disp_code, dp: disp_dp};

    // shad_nxt is what the shadow will hold after this edge, so the glyphs
    // registered at a wrap always belong to the new frame.
    always_comb begin
        scan_tick = sync2 & ~sync3;
        wrap      = scan_tick && (phase == 2'd3);
        phase_nxt = scan_tick ? phase + 2'd1 : phase;
        shad_nxt  = shadow;
        if (wrap) begin
            if (disp_load)         shad_nxt = disp_in;
            else if (load_pending) shad_nxt = pending;
        end
    end

    seg_decode u_dec_lo (.code(digit_code(shad_nxt, {29'd0, 1'b0, phase_nxt})), .seg(lo_seg));
    seg_decode u_dec_hi (.code(digit_code(shad_nxt, {29'd0, 1'b1, phase_nxt})), .seg(hi_seg));

    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            {sync1, sync2, sync3} <= '0;
            phase     <= '0;
            blank_cnt <= CW'(BLANK_CYCLES);
            an        <= '0;
            seg0      <= '0;
            seg1      <= '0;
        end else begin
            sync1 <= scan_clk;
            sync2 <= sync1;
            sync3 <= sync2;
            phase <= phase_nxt;
            if (scan_tick) begin
                blank_cnt <= CW'(BLANK_CYCLES);
                an        <= (BLANK_CYCLES == 0) ? en_of(phase_nxt) : '0;
                seg0      <= {shad_nxt.dp[{1'b0, phase_nxt}], lo_seg};
                seg1      <= {shad_nxt.dp[{1'b1, phase_nxt}], hi_seg};
            end else begin
                if (blank_cnt != '0) blank_cnt <= blank_cnt - CW'(1);
                an <= (blank_cnt <= CW'(1)) ? en_of(phase) : '0;
            end
        end
    end

    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shadow       <= RST_DISP;
            pending      <= RST_DISP;
            load_pending <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= wrap;
            shadow     <= shad_nxt;
            if (wrap) begin
                load_pending <= 1'b0;
                if (disp_load) pending <= disp_in;
            end else if (disp_load) begin
                pending      <= disp_in;
                load_pending <= 1'b1;
            end
        end
    end
endmodule
